regfile_wb_queue: RTL and testbench

- Writeback-side producer for the 64-bit, 32-entry register file; drives its single write port (WriteRegister, WriteData, RegWrite).
- Accepts results from the ALU and memory stages over valid/ready handshakes.
- Buffers them in a small in-order FIFO and retires one write per cycle.
- Optionally exposes pending-write forwarding to the operand-read side, so reads see results not yet committed.

---
 rtl/regfile_wb_queue.sv | 156 +++++++++++++++
 tb/tb_regfile_wb_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_queue
//  Purpose  : In-order writeback queue feeding the register-file write port,
//             with optional pending-write forwarding (macro WB_FWD_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [WIDTH-1:0]         mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [WIDTH-1:0]         alu_data,
    output logic [4:0]               WriteRegister,
    output logic [WIDTH-1:0]         WriteData,
    output logic                     RegWrite,
    input  logic [4:0]               ReadRegister1,
    input  logic [4:0]               ReadRegister2,
    output logic                     fwd_hit1,
    output logic [WIDTH-1:0]         fwd_data1,
    output logic                     fwd_hit2,
    output logic [WIDTH-1:0]         fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int         c_pw       = $clog2(DEPTH);
    localparam int         c_cw       = c_pw + 1;
    localparam logic [4:0] c_zero_reg = 5'd31;

    logic [c_pw-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [c_cw-1:0]  count_q, count_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [4:0]       wreg_q, wreg_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             wen_q, wen_d;

    logic             w_mem_fire, w_alu_fire, w_mem_store, w_alu_store, w_pop;
    logic [1:0]       w_enq_n;
    logic [c_cw:0]    w_alu_occ;
    logic [c_pw-1:0]  w_alu_slot;

    // Readiness looks at occupancy before this edge's pop; the memory result is older and claims space first.
    assign mem_ready   = (count_q < c_cw'(DEPTH));
    assign w_mem_fire  = mem_valid & mem_ready;
    assign w_alu_occ   = {1'b0, count_q} + (c_cw+1)'(w_mem_fire);
    assign alu_ready   = (w_alu_occ < (c_cw+1)'(DEPTH));
    assign w_alu_fire  = alu_valid & alu_ready;

    assign w_mem_store = w_mem_fire & (mem_rd != c_zero_reg);
    assign w_alu_store = w_alu_fire & (alu_rd != c_zero_reg);
    assign w_enq_n     = {1'b0, w_mem_store} + {1'b0, w_alu_store};
    assign w_pop       = (count_q != '0);
    assign w_alu_slot  = w_mem_store ? (wptr_q + c_pw'(1)) : wptr_q;

    always_comb begin
        count_d = count_q + c_cw'(w_enq_n) - c_cw'(w_pop);
        wptr_d  = wptr_q + c_pw'(w_enq_n);
        rptr_d  = rptr_q + c_pw'(w_pop);
        wen_d   = w_pop;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (w_pop) begin
            wreg_d  = rd_q[rptr_q];
            wdata_d = data_q[rptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_mem_store) begin
            rd_q[wptr_q]   <= mem_rd;
            data_q[wptr_q] <= mem_data;
        end
        if (w_alu_store) begin
            rd_q[w_alu_slot]   <= alu_rd;
            data_q[w_alu_slot] <= alu_data;
        end
    end

    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign RegWrite      = wen_q;
    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q == c_cw'(DEPTH));

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest match wins; the output stage is the oldest pending write.
    function automatic logic [WIDTH:0] fwd_lookup(input logic [4:0] rr);
        logic             hit;
        logic [WIDTH-1:0] val;
        logic [c_pw-1:0]  idx;
        hit = 1'b0;
        val = '0;
        if (wen_q && (wreg_q == rr)) begin
            hit = 1'b1;
            val = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + c_pw'(i);
            if ((c_cw'(i) < count_q) && (rd_q[idx] == rr)) begin
                hit = 1'b1;
                val = data_q[idx];
            end
        end
        if (rr == c_zero_reg) begin
            hit = 1'b0;
            val = '0;
        end
        return {hit, val};
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = fwd_lookup(ReadRegister1);
        {fwd_hit2, fwd_data2} = fwd_lookup(ReadRegister2);
    end
`else
    logic w_unused_rr;
    assign w_unused_rr = ^{ReadRegister1, ReadRegister2};
    assign fwd_hit1    = 1'b0;
    assign fwd_data1   = '0;
    assign fwd_hit2    = 1'b0;
    assign fwd_data2   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_queue
//  Purpose  : Scoreboard bench for regfile_wb_queue (DEPTH=4 main instance,
//             DEPTH=2 instance for the full-queue case).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_valid, alu_valid;
    logic [4:0]       mem_rd, alu_rd, ReadRegister1, ReadRegister2;
    logic [WIDTH-1:0] mem_data, alu_data;
    logic             mem_ready, alu_ready, RegWrite, fwd_hit1, fwd_hit2, empty, full;
    logic [4:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData, fwd_data1, fwd_data2;
    logic [2:0]       count;

    logic             d2_mem_valid, d2_alu_valid;
    logic [4:0]       d2_mem_rd, d2_alu_rd, d2_rr1, d2_rr2;
    logic [WIDTH-1:0] d2_mem_data, d2_alu_data;
    logic             d2_mem_ready, d2_alu_ready, d2_RegWrite, d2_hit1, d2_hit2, d2_empty, d2_full;
    logic [4:0]       d2_WriteRegister;
    logic [WIDTH-1:0] d2_WriteData, d2_fdata1, d2_fdata2;
    logic [1:0]       d2_count;

    int  n_pass = 0;
    int  n_total = 0;
    int  m_cnt = 0;
    wr_t sb[$];

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count), .empty(empty), .full(full)
    );

    regfile_wb_queue #(.DEPTH(2), .WIDTH(WIDTH)) u_dut2 (
        .clk(clk), .reset(reset),
        .mem_valid(d2_mem_valid), .mem_ready(d2_mem_ready), .mem_rd(d2_mem_rd), .mem_data(d2_mem_data),
        .alu_valid(d2_alu_valid), .alu_ready(d2_alu_ready), .alu_rd(d2_alu_rd), .alu_data(d2_alu_data),
        .WriteRegister(d2_WriteRegister), .WriteData(d2_WriteData), .RegWrite(d2_RegWrite),
        .ReadRegister1(d2_rr1), .ReadRegister2(d2_rr2),
        .fwd_hit1(d2_hit1), .fwd_data1(d2_fdata1), .fwd_hit2(d2_hit2), .fwd_data2(d2_fdata2),
        .count(d2_count), .empty(d2_empty), .full(d2_full)
    );

    // Write-port scoreboard for the main instance.
    always @(posedge clk) begin
        wr_t exp;
        #1;
        if (reset === 1'b1 && RegWrite === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got rd=%0d data=%0h, none pending", WriteRegister, WriteData);
            end else begin
                exp = sb.pop_front();
                if (WriteRegister !== exp.rd || WriteData !== exp.data)
                    $display("FAIL write_order: got rd=%0d data=%0h expected rd=%0d data=%0h",
                             WriteRegister, WriteData, exp.rd, exp.data);
                else
                    n_pass++;
            end
        end
    end

    task automatic cycle(input logic mv, input logic [4:0] mrd, input logic [WIDTH-1:0] md,
                         input logic av, input logic [4:0] ard, input logic [WIDTH-1:0] ad);
        logic mr, ar;
        int   enq;
        @(negedge clk);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        #1;
        mr  = (m_cnt < DEPTH);
        ar  = ((m_cnt + ((mv && mr) ? 1 : 0)) < DEPTH);
        enq = 0;
        n_total++;
        if (mem_ready !== mr || alu_ready !== ar)
            $display("FAIL ready: got mem=%b alu=%b expected mem=%b alu=%b", mem_ready, alu_ready, mr, ar);
        else
            n_pass++;
        if (mv && mr && mrd != 5'd31) begin sb.push_back('{mrd, md}); enq++; end
        if (av && ar && ard != 5'd31) begin sb.push_back('{ard, ad}); enq++; end
        m_cnt = m_cnt + enq - ((m_cnt > 0) ? 1 : 0);
        @(posedge clk);
        #1;
        n_total++;
        if (count !== 3'(m_cnt) || empty !== (m_cnt == 0) || full !== (m_cnt == DEPTH))
            $display("FAIL occupancy: got count=%0d empty=%b full=%b expected count=%0d", count, empty, full, m_cnt);
        else
            n_pass++;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic test_reset();
        n_total++;
        if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== '0 || count !== 3'd0 ||
            empty !== 1'b1 || full !== 1'b0 || fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0)
            $display("FAIL reset_state: got we=%b wr=%0d wd=%0h cnt=%0d e=%b f=%b h=%b%b expected 0 0 0 0 1 0 00",
                     RegWrite, WriteRegister, WriteData, count, empty, full, fwd_hit1, fwd_hit2);
        else
            n_pass++;
        n_total++;
        if (d2_RegWrite !== 1'b0 || d2_count !== 2'd0 || d2_empty !== 1'b1 || d2_full !== 1'b0)
            $display("FAIL reset_state_d2: got we=%b cnt=%0d e=%b f=%b expected 0 0 1 0",
                     d2_RegWrite, d2_count, d2_empty, d2_full);
        else
            n_pass++;
    endtask

    task automatic test_single();
        cycle(1'b0, 5'd0, '0, 1'b1, 5'd5, 64'd172);
        idle();
        n_total++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 64'd172)
            $display("FAIL single_latency: got we=%b rd=%0d data=%0d expected 1 5 172", RegWrite, WriteRegister, WriteData);
        else
            n_pass++;
        idle();
        n_total++;
        if (RegWrite !== 1'b0 || WriteRegister !== 5'd5 || WriteData !== 64'd172)
            $display("FAIL single_hold: got we=%b rd=%0d data=%0d expected 0 5 172", RegWrite, WriteRegister, WriteData);
        else
            n_pass++;
    endtask

    task automatic test_dual_enqueue();
        cycle(1'b1, 5'd3, 64'd25, 1'b1, 5'd4, 64'd119);
        idle();
        n_total++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd3)
            $display("FAIL dual_first: got we=%b rd=%0d expected 1 3", RegWrite, WriteRegister);
        else
            n_pass++;
        idle();
        n_total++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd4 || WriteData !== 64'd119)
            $display("FAIL dual_second: got we=%b rd=%0d data=%0d expected 1 4 119", RegWrite, WriteRegister, WriteData);
        else
            n_pass++;
        idle();
    endtask

    task automatic test_x31();
        cycle(1'b1, 5'd31, 64'hdead, 1'b1, 5'd31, 64'hbeef);
        idle();
        n_total++;
        if (RegWrite !== 1'b0 || count !== 3'd0)
            $display("FAIL x31_filter: got we=%b count=%0d expected 0 0", RegWrite, count);
        else
            n_pass++;
    endtask

    task automatic test_forwarding();
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd31;
        cycle(1'b1, 5'd7, 64'd10, 1'b1, 5'd7, 64'd20);
        n_total++;
        if (fwd_hit1 !== FWD || fwd_data1 !== (FWD ? 64'd20 : 64'd0) || fwd_hit2 !== 1'b0 || fwd_data2 !== '0)
            $display("FAIL fwd_fifo: got h1=%b d1=%0d h2=%b d2=%0d expected %b %0d 0 0",
                     fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, FWD, FWD ? 20 : 0);
        else
            n_pass++;
        ReadRegister2 = 5'd9;
        idle();
        n_total++;
        if (fwd_hit1 !== FWD || fwd_data1 !== (FWD ? 64'd20 : 64'd0) || fwd_hit2 !== 1'b0)
            $display("FAIL fwd_mixed: got h1=%b d1=%0d h2=%b expected %b %0d 0", fwd_hit1, fwd_data1, fwd_hit2, FWD, FWD ? 20 : 0);
        else
            n_pass++;
        idle();
        n_total++;
        if (fwd_hit1 !== FWD || fwd_data1 !== (FWD ? 64'd20 : 64'd0))
            $display("FAIL fwd_outstage: got h1=%b d1=%0d expected %b %0d", fwd_hit1, fwd_data1, FWD, FWD ? 20 : 0);
        else
            n_pass++;
        idle();
        n_total++;
        if (fwd_hit1 !== 1'b0 || fwd_data1 !== '0)
            $display("FAIL fwd_retired: got h1=%b d1=%0d expected 0 0", fwd_hit1, fwd_data1);
        else
            n_pass++;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
    endtask

    task automatic test_full();
        @(negedge clk);
        d2_mem_valid = 1'b1; d2_mem_rd = 5'd1; d2_mem_data = 64'h11;
        d2_alu_valid = 1'b1; d2_alu_rd = 5'd2; d2_alu_data = 64'h22;
        @(posedge clk); #1;
        n_total++;
        if (d2_full !== 1'b1 || d2_count !== 2'd2 || d2_mem_ready !== 1'b0 || d2_alu_ready !== 1'b0)
            $display("FAIL full_flags: got full=%b cnt=%0d mr=%b ar=%b expected 1 2 0 0",
                     d2_full, d2_count, d2_mem_ready, d2_alu_ready);
        else
            n_pass++;
        @(negedge clk);
        d2_mem_rd = 5'd3; d2_mem_data = 64'h33;
        d2_alu_rd = 5'd4; d2_alu_data = 64'h44;
        @(posedge clk); #1;
        n_total++;
        if (d2_count !== 2'd1 || d2_full !== 1'b0 || d2_RegWrite !== 1'b1 || d2_WriteRegister !== 5'd1 ||
            d2_mem_ready !== 1'b1 || d2_alu_ready !== 1'b0)
            $display("FAIL full_pop: got cnt=%0d full=%b we=%b rd=%0d mr=%b ar=%b expected 1 0 1 1 1 0",
                     d2_count, d2_full, d2_RegWrite, d2_WriteRegister, d2_mem_ready, d2_alu_ready);
        else
            n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (d2_count !== 2'd1 || d2_WriteRegister !== 5'd2 || d2_WriteData !== 64'h22)
            $display("FAIL full_reaccept: got cnt=%0d rd=%0d data=%0h expected 1 2 22", d2_count, d2_WriteRegister, d2_WriteData);
        else
            n_pass++;
        @(negedge clk);
        d2_mem_valid = 1'b0; d2_alu_valid = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (d2_RegWrite !== 1'b1 || d2_WriteRegister !== 5'd3 || d2_WriteData !== 64'h33 || d2_empty !== 1'b1)
            $display("FAIL full_drain: got we=%b rd=%0d data=%0h e=%b expected 1 3 33 1",
                     d2_RegWrite, d2_WriteRegister, d2_WriteData, d2_empty);
        else
            n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (d2_RegWrite !== 1'b0 || d2_WriteRegister !== 5'd3)
            $display("FAIL full_idle: got we=%b rd=%0d expected 0 3", d2_RegWrite, d2_WriteRegister);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            logic [4:0] r1, r2;
            r1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            r2 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            cycle(1'($urandom_range(0, 1)), r1, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), r2, {$urandom, $urandom});
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, 5'd1, 64'h100, 1'b1, 5'd2, 64'h200);
        cycle(1'b1, 5'd3, 64'h300, 1'b1, 5'd4, 64'h400);
        @(negedge clk);
        mem_valid = 1'b0; alu_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_total++;
        if (RegWrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
            $display("FAIL async_reset: got we=%b count=%0d empty=%b expected 0 0 1", RegWrite, count, empty);
        else
            n_pass++;
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        idle(); idle(); idle();
        n_total++;
        if (RegWrite !== 1'b0)
            $display("FAIL stale_write: got we=%b expected 0", RegWrite);
        else
            n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        d2_mem_valid = 1'b0; d2_mem_rd = '0; d2_mem_data = '0;
        d2_alu_valid = 1'b0; d2_alu_rd = '0; d2_alu_data = '0;
        d2_rr1 = '0; d2_rr2 = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_single();
        test_dual_enqueue();
        test_x31();
        test_forwarding();
        test_full();
        test_back_to_back();
        test_reset_midstream();
        n_total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
